muldiv_seq: RTL and testbench
=============================

Name: muldiv_seq

Overview:
- Multicycle sequencer for the MULT/DIV instructions; owns the HI/LO register pair.
- Accepts a start pulse from the main control FSM, latches the operands from regs A/B, iterates 32 cycles, then publishes HI/LO with a one-cycle write pulse.
- Flags divide-by-zero so control can raise the exception.
- The main FSM stalls on `busy` and resumes on `done`.

Parameters:
- WIDTH, 32, operand width; HI/LO are each WIDTH bits.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous active-high reset
- mult_start  in  1  single-cycle request for signed multiply
- div_start  in  1  single-cycle request for signed divide
- op_a  in  WIDTH  multiplicand / dividend (reg A)
- op_b  in  WIDTH  multiplier / divisor (reg B)
- busy  out  1  high while MULT or DIV state active
- done  out  1  one-cycle pulse on completion (including div-by-zero abort)
- hilo_write  out  1  one-cycle pulse when HI/LO updated
- div_zero  out  1  one-cycle pulse with done when divisor==0
- hi  out  WIDTH  HI register
- lo  out  WIDTH  LO register
- unsigned_op  in  1  only present with MULDIV_UNSIGNED_EN

Behaviour:
- Reset (async, any state): state=IDLE; counter=0; busy=done=hilo_write=div_zero=0; hi=lo=0; internal operand/accumulator regs=0.
- FSM states: IDLE, MULT, DIV, FIN.
- IDLE:
  - mult_start=1 → latch op_a/op_b, counter=0, go MULT.
  - Else div_start=1 and op_b!=0 → latch, go DIV.
  - Else div_start=1 and op_b==0 → go FIN with zero flag set.
  - Both starts together: mult wins; div_start is dropped.
- Starts asserted outside IDLE are ignored; no queuing.
- MULT:
  - One Booth radix-2 step per cycle on a 2*WIDTH+1 accumulator.
  - Counter increments; after step WIDTH-1 go FIN.
- DIV:
  - One restoring step per cycle on operand magnitudes.
  - Counter increments; after step WIDTH-1 go FIN.
- FIN (one cycle):
  - done=1, then return to IDLE.
  - If not zero flag: hilo_write=1 and hi/lo load the result on the IDLE-transition edge.
  - If zero flag: div_zero=1, hilo_write=0, hi/lo unchanged.
- busy=1 in MULT and DIV only (0 in IDLE and FIN).
- Latency:
  - Start sampled at edge 0; FIN occupies cycle WIDTH+1, i.e. done visible 33 cycles after start for WIDTH=32.
  - Div-by-zero: done visible 1 cycle after start.
- Arithmetic:
  - MULT: {hi,lo} = signed 64-bit product.
  - DIV: lo = quotient truncated toward zero; hi = remainder with the sign of the dividend.
  - Sign fix-up is applied in FIN.
  - 0x80000000 / -1 → lo=0x80000000, hi=0 (wraps; no overflow flag).
- hi/lo hold their value between operations; they are written only in FIN.
- Reset mid-operation: aborts immediately, no done and no hilo_write; hi/lo cleared to 0.
- Outputs done, hilo_write, div_zero are registered (state-decoded from registered state; no combinational path from start inputs).

Optional Feature:
- Macro: MULDIV_UNSIGNED_EN.
- Defined:
  - Port unsigned_op exists; it is latched with the start.
  - When 1: MULTU/DIVU semantics. Operands are zero-extended, there is no sign fix-up, and the Booth step uses a zero-extended multiplier.
  - Divide-by-zero handling and latency are identical to the signed case.
- Undefined: port absent; all operations signed; logic for the unsigned path not synthesized.

Test Plan:
- Signed multiply: mult_start, a=7, b=0xFFFFFFFD (-3) → done at cycle 33, hilo_write=1, hi=0xFFFFFFFF, lo=0xFFFFFFEB, busy high cycles 1–32.
- Multiply max: a=b=0x7FFFFFFF → hi=0x3FFFFFFF, lo=0x00000001.
- Signed divide: div_start, a=0xFFFFFFF9 (-7), b=2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF. Edge case: a=0x80000000, b=0xFFFFFFFF → lo=0x80000000, hi=0.
- Divide-by-zero: preload hi=lo from a prior op, div_start with b=0 → next cycle done=1, div_zero=1, hilo_write=0, hi/lo unchanged, busy never asserted.
- Contention: mult_start and div_start together → MULT result written. A div_start pulse at cycle 5 of that MULT is ignored: only one done pulse occurs.
- Reset mid-op: assert reset during cycle 10 of a MULT → busy=0, hi=lo=0 immediately; no done. A fresh mult_start after release completes normally.
- With MULDIV_UNSIGNED_EN (extra run): unsigned_op=1, a=b=0xFFFFFFFF → hi=0xFFFFFFFE, lo=0x00000001.

Source files
------------

// File: rtl/muldiv_seq.sv
// muldiv_seq: 32-step MULT/DIV sequencer owning HI/LO; define MULDIV_UNSIGNED_EN for the unsigned_op (MULTU/DIVU) port
module muldiv_seq #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             mult_start,
  input  logic             div_start,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
`ifdef MULDIV_UNSIGNED_EN
  input  logic             unsigned_op,
`endif
  output logic             busy,
  output logic             done,
  output logic             hilo_write,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  localparam logic [1:0] IDLE = 2'd0, MULT = 2'd1, DIV = 2'd2, FIN = 2'd3;
  localparam int AW = 2*WIDTH+1;
  logic [1:0] state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [AW-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] opd_q, opd_d, hi_q, hi_d, lo_q, lo_d;
  logic div_q, div_d, zero_q, zero_d, qneg_q, qneg_d, rneg_q, rneg_d;
  logic uns_in, uns_q;
  logic [WIDTH:0] up_x, m_x, sum;
  logic [WIDTH+1:0] diff;
  logic [AW-1:0] sh, div_nx;
  logic [WIDTH-1:0] mag_a, mag_b, quo, rem;
`ifdef MULDIV_UNSIGNED_EN
  assign uns_in = unsigned_op;
  // unsigned mode is captured with the operands and held for the whole operation
  always_ff @(posedge clk or posedge reset)
    if (reset) uns_q <= 1'b0;
    else if (state_q == IDLE && (mult_start || div_start)) uns_q <= unsigned_op;
`else
  assign uns_in = 1'b0;
  assign uns_q  = 1'b0;
`endif
  // one Booth (or add-shift when unsigned) step and one restoring-divide step, plus operand magnitudes
  always_comb begin
    up_x   = {~uns_q & acc_q[AW-1], acc_q[AW-1:WIDTH+1]};
    m_x    = {~uns_q & opd_q[WIDTH-1], opd_q};
    sum    = uns_q ? (acc_q[1] ? up_x + m_x : up_x)
           : (acc_q[1:0] == 2'b01 ? up_x + m_x : acc_q[1:0] == 2'b10 ? up_x - m_x : up_x);
    sh     = {acc_q[AW-2:0], 1'b0};
    diff   = {1'b0, sh[AW-1:WIDTH]} - {2'b00, opd_q};
    div_nx = diff[WIDTH+1] ? sh : {diff[WIDTH:0], sh[WIDTH-1:1], 1'b1};
    mag_a  = (~uns_in & op_a[WIDTH-1]) ? -op_a : op_a;
    mag_b  = (~uns_in & op_b[WIDTH-1]) ? -op_b : op_b;
    quo    = qneg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    rem    = rneg_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
  end
  // sequencer next state: launch from IDLE, iterate WIDTH steps, publish HI/LO in FIN
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    opd_d   = opd_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    div_d   = div_q;
    zero_d  = zero_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    case (state_q)
      IDLE: begin
        if (mult_start) begin
          state_d = MULT;
          cnt_d   = '0;
          acc_d   = {{WIDTH{1'b0}}, op_b, 1'b0};
          opd_d   = op_a;
          div_d   = 1'b0;
          zero_d  = 1'b0;
        end else if (div_start) begin
          state_d = (op_b == '0) ? FIN : DIV;
          cnt_d   = '0;
          acc_d   = {{(WIDTH+1){1'b0}}, mag_a};
          opd_d   = mag_b;
          div_d   = 1'b1;
          zero_d  = (op_b == '0);
          qneg_d  = ~uns_in & (op_a[WIDTH-1] ^ op_b[WIDTH-1]);
          rneg_d  = ~uns_in & op_a[WIDTH-1];
        end
      end
      MULT, DIV: begin
        acc_d = (state_q == MULT) ? {sum, acc_q[WIDTH:1]} : div_nx;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH-1)) state_d = FIN;
      end
      default: begin
        state_d = IDLE;
        if (!zero_q) begin
          hi_d = div_q ? rem : acc_q[AW-1:WIDTH+1];
          lo_d = div_q ? quo : acc_q[WIDTH:1];
        end
      end
    endcase
  end
  // state and datapath registers; reset aborts any operation and clears HI/LO
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      opd_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      div_q   <= 1'b0;
      zero_q  <= 1'b0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      opd_q   <= opd_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      div_q   <= div_d;
      zero_q  <= zero_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
    end
  assign busy       = (state_q == MULT) || (state_q == DIV);
  assign done       = (state_q == FIN);
  assign hilo_write = (state_q == FIN) && !zero_q;
  assign div_zero   = (state_q == FIN) && zero_q;
  assign hi         = hi_q;
  assign lo         = lo_q;
endmodule

// File: tb/tb_muldiv_seq.sv
// tb_muldiv_seq: directed scoreboard bench for muldiv_seq (unsigned case when MULDIV_UNSIGNED_EN is defined)
module tb_muldiv_seq;
  logic clk = 1'b0, reset = 1'b1, mult_start = 1'b0, div_start = 1'b0, uns = 1'b0;
  logic [31:0] op_a = '0, op_b = '0;
  logic busy, done, hilo_write, div_zero;
  logic [31:0] hi, lo;
  int checks = 0, errors = 0;
  logic [64:0] sb[$];
  logic [63:0] model_hilo = '0;

  muldiv_seq dut (
    .clk(clk),
    .reset(reset),
    .mult_start(mult_start),
    .div_start(div_start),
    .op_a(op_a),
    .op_b(op_b),
`ifdef MULDIV_UNSIGNED_EN
    .unsigned_op(uns),
`endif
    .busy(busy),
    .done(done),
    .hilo_write(hilo_write),
    .div_zero(div_zero),
    .hi(hi),
    .lo(lo)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  function automatic logic [63:0] model(input logic is_div, input logic u, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa, sb_;
    sa  = u ? {32'b0, a} : {{32{a[31]}}, a};
    sb_ = u ? {32'b0, b} : {{32{b[31]}}, b};
    if (!is_div) return sa * sb_;
    return {32'(sa % sb_), 32'(sa / sb_)};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic launch(input logic ms, input logic ds, input logic [31:0] a, input logic [31:0] b, input logic u);
    @(posedge clk); #1;
    mult_start = ms; div_start = ds; op_a = a; op_b = b; uns = u;
    @(posedge clk); #1;
    mult_start = 1'b0; div_start = 1'b0;
  endtask

  task automatic push_exp(input logic ms, input logic [31:0] a, input logic [31:0] b, input logic u);
    logic z;
    logic [63:0] r;
    z = !ms && (b == 32'd0);
    r = z ? model_hilo : model(!ms, u, a, b);
    if (!z) model_hilo = r;
    sb.push_back({z, r});
  endtask

  task automatic await_op(input string tag, input int exp_lat, input int inj);
    int lat, bcnt;
    logic [64:0] e;
    lat = 0; bcnt = 0;
    do begin
      @(negedge clk);
      lat++;
      if (busy) bcnt++;
      div_start = (lat == inj);
    end while (!done && lat < 40);
    div_start = 1'b0;
    e = (sb.size() > 0) ? sb.pop_front() : 65'd0;
    chk({tag, "_latency"}, 64'(lat), 64'(exp_lat));
    chk({tag, "_busy_cycles"}, 64'(bcnt), 64'(exp_lat - 1));
    chk({tag, "_hilo_write"}, 64'(hilo_write), 64'(!e[64]));
    chk({tag, "_div_zero"}, 64'(div_zero), 64'(e[64]));
    @(negedge clk);
    chk({tag, "_hilo"}, {hi, lo}, e[63:0]);
    chk({tag, "_done_cleared"}, 64'({done, hilo_write, div_zero, busy}), 64'd0);
  endtask

  initial begin
    int extra;
    logic [31:0] ra, rb;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_ctrl", 64'({busy, done, hilo_write, div_zero}), 64'd0);
    chk("reset_hilo", {hi, lo}, 64'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    push_exp(1, 32'd7, 32'hFFFFFFFD, 0);
    launch(1, 0, 32'd7, 32'hFFFFFFFD, 0);
    await_op("mul_7x-3", 33, 0);
    chk("mul_7x-3_const", {hi, lo}, 64'hFFFFFFFF_FFFFFFEB);

    push_exp(1, 32'h7FFFFFFF, 32'h7FFFFFFF, 0);
    launch(1, 0, 32'h7FFFFFFF, 32'h7FFFFFFF, 0);
    await_op("mul_max", 33, 0);
    chk("mul_max_const", {hi, lo}, 64'h3FFFFFFF_00000001);

    push_exp(1, 32'h80000000, 32'h80000000, 0);
    launch(1, 0, 32'h80000000, 32'h80000000, 0);
    await_op("mul_minxmin", 33, 0);

    push_exp(0, 32'hFFFFFFF9, 32'd2, 0);
    launch(0, 1, 32'hFFFFFFF9, 32'd2, 0);
    await_op("div_-7/2", 33, 0);
    chk("div_-7/2_const", {hi, lo}, 64'hFFFFFFFF_FFFFFFFD);

    push_exp(0, 32'h80000000, 32'hFFFFFFFF, 0);
    launch(0, 1, 32'h80000000, 32'hFFFFFFFF, 0);
    await_op("div_min/-1", 33, 0);
    chk("div_min/-1_const", {hi, lo}, 64'h00000000_80000000);

    for (int i = 0; i < 4; i++) begin
      ra = $urandom;
      rb = $urandom;
      if (rb == 32'd0) rb = 32'd5;
      push_exp(i[0], ra, rb, 0);
      launch(i[0], !i[0], ra, rb, 0);
      await_op(i[0] ? "mul_rand" : "div_rand", 33, 0);
    end

    push_exp(0, 32'd123, 32'd0, 0);
    launch(0, 1, 32'd123, 32'd0, 0);
    await_op("div_zero", 1, 0);

    push_exp(1, 32'hFFFFFF00, 32'd1000, 0);
    launch(1, 1, 32'hFFFFFF00, 32'd1000, 0);
    await_op("contention", 33, 5);
    extra = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) extra++;
    end
    chk("contention_extra_done", 64'(extra), 64'd0);

    launch(1, 0, 32'd55, 32'd66, 0);
    repeat (9) @(posedge clk);
    #2;
    chk("pre_reset_busy", 64'(busy), 64'd1);
    reset = 1'b1;
    #1;
    chk("midreset_ctrl", 64'({busy, done, hilo_write}), 64'd0);
    chk("midreset_hilo", {hi, lo}, 64'd0);
    model_hilo = '0;
    @(posedge clk); #1;
    reset = 1'b0;
    extra = 0;
    repeat (40) begin
      @(negedge clk);
      if (done || hilo_write) extra++;
    end
    chk("midreset_no_done", 64'(extra), 64'd0);

    push_exp(1, 32'd1234, 32'hFFFFFF85, 0);
    launch(1, 0, 32'd1234, 32'hFFFFFF85, 0);
    await_op("mul_after_reset", 33, 0);

`ifdef MULDIV_UNSIGNED_EN
    push_exp(1, 32'hFFFFFFFF, 32'hFFFFFFFF, 1);
    launch(1, 0, 32'hFFFFFFFF, 32'hFFFFFFFF, 1);
    await_op("multu_max", 33, 0);
    chk("multu_max_const", {hi, lo}, 64'hFFFFFFFE_00000001);
    push_exp(0, 32'hFFFFFFFF, 32'd2, 1);
    launch(0, 1, 32'hFFFFFFFF, 32'd2, 1);
    await_op("divu", 33, 0);
    push_exp(0, 32'hFFFFFFFF, 32'd0, 1);
    launch(0, 1, 32'hFFFFFFFF, 32'd0, 1);
    await_op("divu_zero", 1, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
